// File: rtl/onchip_mem_copier_if.sv
// Avalon-MM word port between the copier (master) and the on-chip RAM second slave port.
interface onchip_mem_copier_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/onchip_mem_copier.sv
// Overlap-safe on-chip RAM block copier, 3 cycles/word (RD, CAP, WR), memory never stalls.
// ONCHIP_MEM_COPIER_FILL_EN adds a 1 cycle/word constant-fill mode via fill_en_i/fill_value_i.
module onchip_mem_copier #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5320
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_i,
  input  logic [ADDR_W-1:0]   dst_i,
  input  logic [ADDR_W:0]     len_i,
  input  logic                abort_i,
`ifdef ONCHIP_MEM_COPIER_FILL_EN
  input  logic                fill_en_i,
  input  logic [DATA_W-1:0]   fill_value_i,
`endif
  onchip_mem_copier_if.master mem,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W:0]     words_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RD, S_CAP, S_WR, S_DONE
  } state_t;

  localparam int EXT_W = ADDR_W + 2;
  localparam logic [ADDR_W:0]   ONE_L = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [ADDR_W:0]     rem_q, words_q;
  logic [DATA_W-1:0]   data_q;
  logic                desc_q, err_q;
  logic                fill_q;
  logic [DATA_W-1:0]   fill_val_q;

  logic [EXT_W-1:0]    src_x, dst_x, len_x, src_end, dst_end;
  logic                range_bad, desc;

`ifdef ONCHIP_MEM_COPIER_FILL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      fill_q     <= fill_en_i;
      fill_val_q <= fill_value_i;
    end
  end
`else
  assign fill_q     = 1'b0;
  assign fill_val_q = '0;
`endif

  // During CHECK the pointers and remaining count still hold the operands latched at start.
  assign src_x     = {2'b00, rd_ptr_q};
  assign dst_x     = {2'b00, wr_ptr_q};
  assign len_x     = {1'b0, rem_q};
  assign src_end   = src_x + len_x;
  assign dst_end   = dst_x + len_x;
  assign range_bad = (dst_end > EXT_W'(DEPTH)) || (!fill_q && (src_end > EXT_W'(DEPTH)));
  assign desc      = !fill_q && (dst_x > src_x) && (dst_x < src_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: begin
        if (range_bad || rem_q == '0 || abort_i) state_d = S_DONE;
        else if (fill_q)                         state_d = S_WR;
        else                                     state_d = S_RD;
      end
      S_RD:    state_d = abort_i ? S_DONE : S_CAP;
      S_CAP:   state_d = abort_i ? S_DONE : S_WR;
      S_WR: begin
        if (abort_i || rem_q == ONE_L) state_d = S_DONE;
        else if (fill_q)               state_d = S_WR;
        else                           state_d = S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem.address    = '0;
    mem.chipselect = 1'b0;
    mem.write      = 1'b0;
    mem.byteenable = '0;
    mem.writedata  = '0;
    case (state_q)
      S_RD: begin
        mem.address    = rd_ptr_q;
        mem.chipselect = 1'b1;
        mem.byteenable = '1;
      end
      S_WR: begin
        mem.address    = wr_ptr_q;
        mem.chipselect = 1'b1;
        mem.write      = 1'b1;
        mem.byteenable = '1;
        mem.writedata  = fill_q ? fill_val_q : data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rem_q    <= '0;
      words_q  <= '0;
      data_q   <= '0;
      desc_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          rd_ptr_q <= src_i;
          wr_ptr_q <= dst_i;
          rem_q    <= len_i;
          words_q  <= '0;
          err_q    <= 1'b0;
        end
        S_CHECK: begin
          if (range_bad) err_q <= 1'b1;
          desc_q <= desc;
          // Overlapping forward move walks from the top so no source word is clobbered early.
          if (desc) begin
            rd_ptr_q <= rd_ptr_q + ADDR_W'(rem_q - ONE_L);
            wr_ptr_q <= wr_ptr_q + ADDR_W'(rem_q - ONE_L);
          end
        end
        S_CAP: data_q <= mem.readdata;
        S_WR: begin
          words_q <= words_q + ONE_L;
          rem_q   <= rem_q - ONE_L;
          if (desc_q) begin
            rd_ptr_q <= rd_ptr_q - ONE_A;
            wr_ptr_q <= wr_ptr_q - ONE_A;
          end else begin
            rd_ptr_q <= rd_ptr_q + ONE_A;
            wr_ptr_q <= wr_ptr_q + ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = err_q;
  assign words_done_o = words_q;

endmodule

// File: tb/tb_onchip_mem_copier.sv
// Randomized self-checking bench for onchip_mem_copier against a memmove-style reference model.
module tb_onchip_mem_copier;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5320;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic [ADDR_W-1:0] src_i = '0;
  logic [ADDR_W-1:0] dst_i = '0;
  logic [ADDR_W:0]   len_i = '0;
  logic              busy_o, done_o, err_o;
  logic [ADDR_W:0]   words_done_o;
`ifdef ONCHIP_MEM_COPIER_FILL_EN
  logic              fill_en_i = 1'b0;
  logic [DATA_W-1:0] fill_value_i = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  onchip_mem_copier_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_copier #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .src_i        (src_i),
    .dst_i        (dst_i),
    .len_i        (len_i),
    .abort_i      (abort_i),
`ifdef ONCHIP_MEM_COPIER_FILL_EN
    .fill_en_i    (fill_en_i),
    .fill_value_i (fill_value_i),
`endif
    .mem          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .words_done_o (words_done_o)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] exp_ram [DEPTH];

  // On-chip RAM: synchronous write, registered read data one cycle after the address.
  always @(posedge clk) begin
    if (bus.chipselect && bus.write && bus.address < DEPTH)
      ram[bus.address] <= bus.writedata;
    if (bus.chipselect && !bus.write && bus.address < DEPTH)
      bus.readdata <= ram[bus.address];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int src, input int dst, input int len, input int abort_k,
                         input bit start_busy, input bit fill, input logic [DATA_W-1:0] fv);
    bit bad, desc;
    int nw, exp_lat, exp_first, lat, wr_cnt, cs_cnt, oob, first_wr, run, max_run, mism;
    exp_ram = ram;
    bad  = fill ? (dst + len > DEPTH) : ((src + len > DEPTH) || (dst + len > DEPTH));
    desc = !fill && (dst > src) && (dst < src + len);
    nw   = bad ? 0 : ((abort_k > 0 && abort_k < len) ? abort_k : len);
    for (int i = 0; i < nw; i++) begin
      int j;
      j = desc ? (len - 1 - i) : i;
      exp_ram[dst + j] = fill ? fv : ram[src + j];
    end
    exp_lat   = fill ? (nw + 2) : (3 * nw + 2);
    exp_first = (nw == 0) ? -1 : (desc ? dst + len - 1 : dst);

    src_i = src[ADDR_W-1:0];
    dst_i = dst[ADDR_W-1:0];
    len_i = len[ADDR_W:0];
`ifdef ONCHIP_MEM_COPIER_FILL_EN
    fill_en_i    = fill;
    fill_value_i = fv;
`endif
    start_i = 1'b1;
    lat = -1; wr_cnt = 0; cs_cnt = 0; oob = 0; first_wr = -1; run = 0; max_run = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      if (bus.chipselect) begin
        cs_cnt++;
        if (bus.address >= DEPTH) oob++;
      end
      if (bus.chipselect && bus.write) begin
        wr_cnt++;
        if (first_wr == -1) first_wr = int'(bus.address);
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done_o) begin
        lat = n;
        break;
      end
      if (start_busy && n == 3) begin
        start_i = 1'b1;
        src_i = '0; dst_i = 13'd1; len_i = 14'd2;
      end
      if (abort_k > 0 && bus.chipselect && bus.write && wr_cnt == abort_k) abort_i = 1'b1;
    end
    chk("done_latency", lat, exp_lat);
    chk("err", err_o, bad);
    chk("words_done", words_done_o, nw);
    chk("write_count", wr_cnt, nw);
    chk("cs_count", cs_cnt, fill ? nw : 2 * nw);
    chk("addr_in_range", oob, 0);
    chk("first_wr_addr", first_wr, exp_first);
    if (fill) chk("fill_run", max_run, nw);
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_done", busy_o, 0);
    chk("done_pulse_len", done_o, 0);
    chk("err_sticky", err_o, bad);
    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== exp_ram[i]) mism++;
    chk("mem_contents", mism, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
    for (int i = 0; i < 4; i++) ram[10 + i] <= 32'hA0 + i;
    for (int i = 0; i < 5; i++) ram[20 + i] <= i + 1;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_words", words_done_o, 0);
    chk("rst_cs", bus.chipselect, 0);
    chk("rst_be", bus.byteenable, 0);
    chk("rst_addr", bus.address, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset asserted in cycle 5 of a len=4 job.
    src_i = 13'd200; dst_i = 13'd300; len_i = 14'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy_o, 1);
    chk("mid_words", words_done_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cs", bus.chipselect, 0);
    chk("mid_rst_words", words_done_o, 0);
    chk("mid_rst_done", done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(0, 100, 1, 0, 1'b0, 1'b0, '0);

    run_job(10, 50, 4, 0, 1'b0, 1'b0, '0);
    chk("ram53", ram[53], 32'hA3);
    run_job(20, 22, 5, 0, 1'b0, 1'b0, '0);
    chk("ram26", ram[26], 32'd5);
    run_job(5300, 0, 21, 0, 1'b0, 1'b0, '0);
    run_job(40, 60, 0, 0, 1'b0, 1'b0, '0);
    run_job(30, 7, 3, 0, 1'b0, 1'b0, '0);
    run_job(400, 400, 6, 0, 1'b0, 1'b0, '0);
    run_job(1000, 2000, 8, 3, 1'b1, 1'b0, '0);
    run_job(DEPTH - 5, DEPTH - 10, 5, 0, 1'b0, 1'b0, '0);
`ifdef ONCHIP_MEM_COPIER_FILL_EN
    run_job(0, 0, 16, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    run_job(DEPTH - 1, DEPTH - 3, 4, 0, 1'b0, 1'b1, 32'h1234);
`endif

    for (int t = 0; t < 40; t++) begin
      int base, s, d, l, k;
      bit f;
      base = $urandom_range(0, 5300);
      s = base + $urandom_range(0, 15);
      d = base + $urandom_range(0, 15);
      l = $urandom_range(0, 24);
      k = ($urandom_range(0, 3) == 0 && l > 0) ? $urandom_range(1, l) : 0;
      f = 1'b0;
`ifdef ONCHIP_MEM_COPIER_FILL_EN
      f = ($urandom_range(0, 3) == 0);
`endif
      run_job(s, d, l, k, 1'b0, f, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
